// File: rtl/spi_comm_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_comm_master_if
// Description : Request/response bus and SPI pin bundle for spi_comm_master.
//               The master modport is the SPI master's view; the slave
//               modport is the requester/slave-device side of the same wires.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_comm_master_if;
    logic        start;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        more;
    logic        busy;
    logic        done;
    logic [7:0]  sta;
    logic [7:0]  rdata;
    logic        SCLK;
    logic        SS;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  start, cmd, addr, wdata, more, MISO,
        output busy, done, sta, rdata, SCLK, SS, MOSI
    );

    modport slave (
        output start, cmd, addr, wdata, more, MISO,
        input  busy, done, sta, rdata, SCLK, SS, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_comm_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_comm_master
// Description : SPI mode-0 master issuing 1-4 byte framed commands (LSB
//               first) to the SPI_COMM slave; returns the status byte and
//               read data. Optional burst continuation is compiled in with
//               the macro SPI_MASTER_CONT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_comm_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CS_SETUP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_comm_master_if.master bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_HIGH  = 3'd2;
    localparam logic [2:0] c_ST_LOW   = 3'd3;
    localparam logic [2:0] c_ST_END   = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;

    localparam logic [15:0] c_DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] c_GAP_LAST   = 16'(GAP_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_cnt;
    logic [7:0]  r_cmd;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [2:0]  r_bit;
    logic [2:0]  r_byte;
    logic [7:0]  r_rx;
    logic [7:0]  r_sta;
    logic [7:0]  r_rdata;
    logic        r_cont_done;
    logic [7:0]  w_cur_byte;
    logic [2:0]  w_last;
    logic        w_is_rd;
    logic        w_cont_go;
    logic [7:0]  w_rx_next;

    // Index of the final byte in the frame equals the mode field
    assign w_last    = {1'b0, r_cmd[1:0]};
    // Modes 01/11 carry a data byte; WRITE=0 makes it a read
    assign w_is_rd   = r_cmd[0] & ~r_cmd[3];
    assign w_rx_next = {bus.MISO, r_rx[7:1]};

`ifdef SPI_MASTER_CONT_EN
    // Burst continues only for data-carrying modes with CONT set
    assign w_cont_go = r_cmd[2] & r_cmd[0] & bus.more;
`else
    logic w_unused_more;
    assign w_unused_more = bus.more;
    assign w_cont_go     = 1'b0;
`endif

    // Byte currently on the wire; indices past the frame read as zero
    always_comb begin
        w_cur_byte = 8'h00;
        case (r_byte)
            3'd0: w_cur_byte = r_cmd;
            3'd1: begin
                if (r_cmd[1:0] == 2'b01)
                    w_cur_byte = r_cmd[3] ? r_wdata : 8'h00;
                else if (r_cmd[1])
                    w_cur_byte = r_addr[7:0];
            end
            3'd2: w_cur_byte = r_cmd[1] ? r_addr[15:8] : 8'h00;
            3'd3: begin
                if (r_cmd[1:0] == 2'b11)
                    w_cur_byte = r_cmd[3] ? r_wdata : 8'h00;
            end
            default: w_cur_byte = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.start) w_next = c_ST_SETUP;
            c_ST_SETUP: if (r_cnt == c_SETUP_LAST) w_next = c_ST_HIGH;
            c_ST_HIGH:  if (r_cnt == c_DIV_LAST) w_next = c_ST_LOW;
            c_ST_LOW: begin
                if (r_cnt == c_DIV_LAST)
                    w_next = (r_byte == w_last + 3'd1) ? c_ST_END : c_ST_HIGH;
            end
            c_ST_END:   w_next = c_ST_GAP;
            c_ST_GAP:   if (r_cnt == c_GAP_LAST) w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // Pin and handshake outputs decoded from state
    always_comb begin
        bus.SCLK = 1'b0;
        bus.SS   = 1'b1;
        bus.MOSI = 1'b0;
        bus.busy = 1'b1;
        bus.done = r_cont_done;
        case (r_state)
            c_ST_IDLE:  bus.busy = 1'b0;
            c_ST_SETUP: begin
                bus.SS   = 1'b0;
                bus.MOSI = w_cur_byte[r_bit];
            end
            c_ST_HIGH: begin
                bus.SS   = 1'b0;
                bus.SCLK = 1'b1;
                bus.MOSI = w_cur_byte[r_bit];
            end
            c_ST_LOW: begin
                bus.SS   = 1'b0;
                bus.MOSI = w_cur_byte[r_bit];
            end
            c_ST_END:   bus.done = 1'b1;
            default:    bus.busy = 1'b1;
        endcase
    end

    assign bus.sta   = r_sta;
    assign bus.rdata = r_rdata;

    // Phase timer restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_cnt <= 16'd0;
        else if (w_next != r_state) r_cnt <= 16'd0;
        else                       r_cnt <= r_cnt + 16'd1;
    end

    // Request latch, bit/byte sequencing and MISO capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd       <= 8'h00;
            r_addr      <= 16'h0000;
            r_wdata     <= 8'h00;
            r_bit       <= 3'd0;
            r_byte      <= 3'd0;
            r_rx        <= 8'h00;
            r_sta       <= 8'h00;
            r_rdata     <= 8'h00;
            r_cont_done <= 1'b0;
        end else begin
            r_cont_done <= 1'b0;
            if (r_state == c_ST_IDLE && bus.start) begin
                r_cmd   <= bus.cmd;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_bit   <= 3'd0;
                r_byte  <= 3'd0;
            end
            // Rising SCLK: shift MISO in and publish completed bytes
            if (w_next == c_ST_HIGH && r_state != c_ST_HIGH) begin
                r_rx <= w_rx_next;
                if (r_bit == 3'd7) begin
                    if (r_byte == 3'd0)
                        r_sta <= w_rx_next;
                    if (r_byte == w_last && w_is_rd)
                        r_rdata <= w_rx_next;
                end
            end
            // Falling SCLK: step to the next bit, or repeat the data byte in a burst
            if (r_state == c_ST_HIGH && w_next == c_ST_LOW) begin
                if (r_bit == 3'd7) begin
                    r_bit <= 3'd0;
                    if (r_byte == w_last && r_byte != 3'd0 && w_cont_go) begin
                        r_wdata     <= bus.wdata;
                        r_cont_done <= 1'b1;
                    end else begin
                        r_byte <= r_byte + 3'd1;
                    end
                end else begin
                    r_bit <= r_bit + 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
